// File: rtl/multiboot_ctrl_if.sv
// CPU register port of the multiboot controller: write strobe, address, data in and
// combinational read-back.
interface multiboot_ctrl_if;
    logic       cpu_wr;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;

    modport master (
        output cpu_wr,
        output cpu_addr,
        output cpu_din,
        input  cpu_dout
    );

    modport slave (
        input  cpu_wr,
        input  cpu_addr,
        input  cpu_din,
        output cpu_dout
    );
endinterface

// File: rtl/multiboot_ctrl.sv
// Arbitrates CPU, hotkey and watchdog boot requests and sequences a stable SPI
// bitstream address plus a shaped reboot pulse into the ICAP reboot logic.
module multiboot_ctrl #(
    parameter logic [23:0] DEFAULT_ADDR = 24'h0BC000,
    parameter logic [23:0] GOLDEN_ADDR  = 24'h000000,
    parameter int          PULSE_LEN    = 8,
    parameter int          HOLD_CYCLES  = 64,
    parameter int          WDT_W        = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    multiboot_ctrl_if.slave        cpu,
    input  logic                   hotkey_boot,
    input  logic                   wdt_kick,
    output logic                   reboot,
    output logic [23:0]            spi_addr,
    output logic                   busy,
    output logic                   boot_fail
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [15:0] PULSE_LOAD = 16'(PULSE_LEN - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] WAIT_LOAD  = 16'hFFFF;

    logic [2:0]       state;
    logic [15:0]      seq_cnt;
    logic [23:0]      shadow;
    logic             wdt_en;
    logic [WDT_W-1:0] wdt_cnt;
    logic             hotkey_q;

    logic             ctrl_wr;
    logic             cpu_req;
    logic             hotkey_rise;
    logic             wdt_hit;
    logic             boot_req;
    logic [23:0]      boot_target;

    assign ctrl_wr     = cpu.cpu_wr && (cpu.cpu_addr == 2'd3);
    assign cpu_req     = ctrl_wr && cpu.cpu_din[0] && (cpu.cpu_din[7:4] == 4'hA);
    assign hotkey_rise = hotkey_boot && !hotkey_q;
    assign wdt_hit     = wdt_en && (wdt_cnt == '1);
    assign busy        = (state != S_IDLE);

    // Same-cycle priority hotkey > watchdog > CPU; losers are simply dropped.
    always_comb begin
        boot_req    = 1'b0;
        boot_target = shadow;
        if (hotkey_rise || wdt_hit) begin
            boot_req    = 1'b1;
            boot_target = GOLDEN_ADDR;
        end else if (cpu_req) begin
            boot_req    = 1'b1;
            boot_target = shadow;
        end
    end

    always_comb begin
        cpu.cpu_dout = 8'h00;
        case (cpu.cpu_addr)
            2'd0:    cpu.cpu_dout = shadow[7:0];
            2'd1:    cpu.cpu_dout = shadow[15:8];
            2'd2:    cpu.cpu_dout = shadow[23:16];
            default: cpu.cpu_dout = {4'h0, busy, boot_fail, wdt_en, 1'b0};
        endcase
    end

    // Shadow bytes are locked while a sequence runs so the target cannot shift under it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= DEFAULT_ADDR;
        end else if (cpu.cpu_wr && !busy) begin
            case (cpu.cpu_addr)
                2'd0:    shadow[7:0]   <= cpu.cpu_din;
                2'd1:    shadow[15:8]  <= cpu.cpu_din;
                2'd2:    shadow[23:16] <= cpu.cpu_din;
                default: shadow        <= shadow;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_en  <= 1'b0;
            wdt_cnt <= '0;
        end else begin
            if (ctrl_wr) begin
                wdt_en <= cpu.cpu_din[1];
            end
            if (!wdt_en || wdt_kick || ctrl_wr || wdt_hit) begin
                wdt_cnt <= '0;
            end else begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hotkey_q <= 1'b0;
        end else begin
            hotkey_q <= hotkey_boot;
        end
    end

    // seq_cnt is reloaded on entry to each timed state and counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            seq_cnt   <= 16'd0;
            reboot    <= 1'b0;
            spi_addr  <= DEFAULT_ADDR;
            boot_fail <= 1'b0;
        end else begin
            if (ctrl_wr && cpu.cpu_din[2]) begin
                boot_fail <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    reboot <= 1'b0;
                    if (boot_req) begin
                        spi_addr <= boot_target;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    reboot  <= 1'b1;
                    seq_cnt <= PULSE_LOAD;
                    state   <= S_PULSE;
                end
                S_PULSE: begin
                    if (seq_cnt == 16'd0) begin
                        reboot  <= 1'b0;
                        seq_cnt <= HOLD_LOAD;
                        state   <= S_HOLD;
                    end else begin
                        seq_cnt <= seq_cnt - 16'd1;
                    end
                end
                S_HOLD: begin
                    if (seq_cnt == 16'd0) begin
                        seq_cnt <= WAIT_LOAD;
                        state   <= S_WAIT;
                    end else begin
                        seq_cnt <= seq_cnt - 16'd1;
                    end
                end
                S_WAIT: begin
                    // Still running after the full window: the reconfiguration did not happen.
                    if (seq_cnt == 16'd0) begin
                        boot_fail <= 1'b1;
                        spi_addr  <= shadow;
                        state     <= S_IDLE;
                    end else begin
                        seq_cnt <= seq_cnt - 16'd1;
                    end
                end
                default: begin
                    reboot <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Self-checking bench for multiboot_ctrl: register vectors plus a pulse scoreboard
// covering CPU, hotkey, watchdog and WAIT-expiry sequences.
module tb_multiboot_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hotkey_boot;
    logic        wdt_kick;
    logic        reboot;
    logic [23:0] spi_addr;
    logic        busy;
    logic        boot_fail;

    multiboot_ctrl_if bus ();

    multiboot_ctrl #(.WDT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (bus.slave),
        .hotkey_boot (hotkey_boot),
        .wdt_kick    (wdt_kick),
        .reboot      (reboot),
        .spi_addr    (spi_addr),
        .busy        (busy),
        .boot_fail   (boot_fail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] wa;
        logic [7:0] wd;
        logic [1:0] ra;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [23:0] addr;
        int          len;
        int          rise;
    } pulse_t;

    pulse_t      exp_q[$];
    logic [7:0]  rd_q[$];
    int          rd_ptr = 0;

    logic [23:0] obs_addr [64];
    int          obs_len  [64];
    int          obs_rise [64];
    bit          obs_chg  [64];
    int          obs_cnt = 0;

    bit          in_pulse = 1'b0;
    int          cur_len;
    int          cur_rise;
    logic [23:0] cur_addr;
    bit          cur_chg;

    // Records every reboot pulse: start cycle, length, and whether spi_addr moved.
    always @(negedge clk) begin
        if (rst) begin
            in_pulse = 1'b0;
        end else if (reboot && !in_pulse) begin
            in_pulse = 1'b1;
            cur_len  = 1;
            cur_rise = cyc;
            cur_addr = spi_addr;
            cur_chg  = 1'b0;
        end else if (reboot) begin
            cur_len = cur_len + 1;
            if (spi_addr !== cur_addr) cur_chg = 1'b1;
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            if (obs_cnt < 64) begin
                obs_addr[obs_cnt] = cur_addr;
                obs_len[obs_cnt]  = cur_len;
                obs_rise[obs_cnt] = cur_rise;
                obs_chg[obs_cnt]  = cur_chg;
                obs_cnt = obs_cnt + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpuWrite(input logic [1:0] a, input logic [7:0] d, output int w);
        @(negedge clk);
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
        w = cyc;
        @(negedge clk);
        bus.cpu_wr = 1'b0;
    endtask

    task automatic cpuRead(input logic [1:0] a, output logic [7:0] d);
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = a;
        #1;
        d = bus.cpu_dout;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int         w;
        logic [7:0] d;
        logic [7:0] e;
        cpuWrite(v.wa, v.wd, w);
        rd_q.push_back(v.exp_rd);
        cpuRead(v.ra, d);
        e = rd_q.pop_front();
        checkOutput($sformatf("vec%0d_read", idx), 32'(d), 32'(e));
        checkOutput($sformatf("vec%0d_busy", idx), 32'(busy), 32'(0));
    endtask

    task automatic waitPulse(input string name, input int budget);
        pulse_t e;
        int     n;
        n = 0;
        while (n < budget && obs_cnt <= rd_ptr) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput({name, "_seen"}, 32'(obs_cnt > rd_ptr), 32'(1));
        if (exp_q.size() == 0) begin
            checkOutput({name, "_expected"}, 32'(0), 32'(1));
        end else begin
            e = exp_q.pop_front();
            if (obs_cnt > rd_ptr) begin
                checkOutput({name, "_addr"}, 32'(obs_addr[rd_ptr]), 32'(e.addr));
                checkOutput({name, "_len"}, obs_len[rd_ptr], e.len);
                checkOutput({name, "_rise"}, obs_rise[rd_ptr], e.rise);
                checkOutput({name, "_addr_stable"}, 32'(obs_chg[rd_ptr]), 32'(0));
                rd_ptr = rd_ptr + 1;
            end
        end
    endtask

    task automatic resetDut(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput({name, "_reboot"}, 32'(reboot), 32'(0));
        checkOutput({name, "_busy"}, 32'(busy), 32'(0));
        checkOutput({name, "_spi_addr"}, 32'(spi_addr), 32'h0BC000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t       vecs[10];
        logic [7:0] d;
        logic [7:0] rst_rd[4];
        int         w;
        int         base;
        int         n;

        vecs[0] = '{wa: 2'd0, wd: 8'h56, ra: 2'd0, exp_rd: 8'h56};
        vecs[1] = '{wa: 2'd1, wd: 8'h34, ra: 2'd1, exp_rd: 8'h34};
        vecs[2] = '{wa: 2'd2, wd: 8'h12, ra: 2'd2, exp_rd: 8'h12};
        vecs[3] = '{wa: 2'd3, wd: 8'h51, ra: 2'd3, exp_rd: 8'h00};
        vecs[4] = '{wa: 2'd3, wd: 8'h53, ra: 2'd3, exp_rd: 8'h02};
        vecs[5] = '{wa: 2'd3, wd: 8'h00, ra: 2'd3, exp_rd: 8'h00};
        vecs[6] = '{wa: 2'd3, wd: 8'hA0, ra: 2'd0, exp_rd: 8'h56};
        vecs[7] = '{wa: 2'd0, wd: 8'h00, ra: 2'd0, exp_rd: 8'h00};
        vecs[8] = '{wa: 2'd1, wd: 8'hC0, ra: 2'd1, exp_rd: 8'hC0};
        vecs[9] = '{wa: 2'd2, wd: 8'h0B, ra: 2'd2, exp_rd: 8'h0B};
        rst_rd[0] = 8'h00;
        rst_rd[1] = 8'hC0;
        rst_rd[2] = 8'h0B;
        rst_rd[3] = 8'h00;

        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 2'd0;
        bus.cpu_din  = 8'h00;
        hotkey_boot  = 1'b0;
        wdt_kick     = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_reboot", 32'(reboot), 32'(0));
        checkOutput("rst_spi_addr", 32'(spi_addr), 32'h0BC000);
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_boot_fail", 32'(boot_fail), 32'(0));
        for (int i = 0; i < 4; i++) begin
            cpuRead(2'(i), d);
            checkOutput($sformatf("rst_read%0d", i), 32'(d), 32'(rst_rd[i]));
        end

        $display("[TB] register vectors");
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);
        checkOutput("idle_spi_addr", 32'(spi_addr), 32'h0BC000);
        checkOutput("no_pulse_from_regs", obs_cnt, 0);

        $display("[TB] CPU boot, shadow write during pulse");
        cpuWrite(2'd3, 8'hA1, w);
        exp_q.push_back('{addr: 24'h0BC000, len: 8, rise: w + 2});
        checkOutput("cpu_boot_busy", 32'(busy), 32'(1));
        cpuWrite(2'd1, 8'h77, n);
        checkOutput("pulse_write_reboot", 32'(reboot), 32'(1));
        waitPulse("cpu_boot", 50);
        cpuRead(2'd1, d);
        checkOutput("shadow_locked", 32'(d), 32'hC0);
        resetDut("rst_after_cpu");

        $display("[TB] hotkey vs CPU, busy hotkey, reset in HOLD");
        @(negedge clk);
        hotkey_boot  = 1'b1;
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = 2'd3;
        bus.cpu_din  = 8'hA1;
        w = cyc;
        exp_q.push_back('{addr: 24'h000000, len: 8, rise: w + 2});
        @(negedge clk);
        bus.cpu_wr = 1'b0;
        waitPulse("hotkey_boot", 50);
        hotkey_boot = 1'b0;
        @(negedge clk);
        hotkey_boot = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("busy_hotkey_dropped", obs_cnt, rd_ptr);
        checkOutput("hold_busy", 32'(busy), 32'(1));
        checkOutput("hold_spi_addr", 32'(spi_addr), 32'h000000);
        hotkey_boot = 1'b0;
        @(negedge clk);
        resetDut("rst_in_hold");
        cpuRead(2'd3, d);
        checkOutput("rst_hold_ctrl_read", 32'(d), 32'h00);

        $display("[TB] watchdog timeout");
        cpuWrite(2'd3, 8'h02, w);
        exp_q.push_back('{addr: 24'h000000, len: 8, rise: w + 258});
        waitPulse("wdt_boot", 400);
        resetDut("rst_after_wdt");

        $display("[TB] watchdog kicked");
        cpuWrite(2'd3, 8'h02, w);
        base = obs_cnt;
        for (int k = 0; k < 20; k++) begin
            repeat (99) @(negedge clk);
            wdt_kick = 1'b1;
            @(negedge clk);
            wdt_kick = 1'b0;
        end
        checkOutput("kicked_no_pulse", obs_cnt, base);
        checkOutput("kicked_busy", 32'(busy), 32'(0));
        cpuWrite(2'd3, 8'h00, w);

        $display("[TB] WAIT expiry");
        cpuWrite(2'd0, 8'h56, w);
        cpuWrite(2'd1, 8'h34, w);
        cpuWrite(2'd2, 8'h12, w);
        @(negedge clk);
        hotkey_boot = 1'b1;
        w = cyc;
        exp_q.push_back('{addr: 24'h000000, len: 8, rise: w + 2});
        waitPulse("expire_boot", 50);
        hotkey_boot = 1'b0;
        n = 0;
        while (busy && n < 70000) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput("expire_busy", 32'(busy), 32'(0));
        checkOutput("expire_cycle", cyc, w + 65610);
        checkOutput("expire_boot_fail", 32'(boot_fail), 32'(1));
        checkOutput("expire_spi_addr", 32'(spi_addr), 32'h123456);
        cpuRead(2'd3, d);
        checkOutput("expire_ctrl_read", 32'(d), 32'h04);
        cpuWrite(2'd3, 8'h04, w);
        checkOutput("clear_boot_fail", 32'(boot_fail), 32'(0));
        cpuRead(2'd3, d);
        checkOutput("clear_ctrl_read", 32'(d), 32'h00);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        checkOutput("no_extra_pulses", obs_cnt, rd_ptr);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
